// File: rtl/regfile_write_arbiter_pkg.sv
// rtl/regfile_write_arbiter_pkg.sv - shared widths, grant codes, arbiter state and register legality helper
package regfile_arb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam logic [31:0] DEFAULT_PERIPH_MASK = 32'h0002_0F6E;
    localparam logic [1:0] GRANT_CPU = 2'd0;

    typedef enum logic {
        ARB_NORMAL,
        ARB_FORCE
    } arb_state_t;

    function automatic logic reg_legal(input logic [31:0] mask, input logic [REG_ADDR_W-1:0] r);
        return (r != '0) && mask[r];
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// rtl/regfile_write_arbiter_if.sv - CPU writeback, peripheral handshake and register-file write bundle
interface regfile_write_arbiter_if #(
    parameter int NUM_PERIPH = 2
);
    import regfile_arb_pkg::*;

    logic                           cpu_we;
    logic [REG_ADDR_W-1:0]          cpu_wreg;
    logic [DATA_W-1:0]              cpu_wdata;
    logic                           cpu_stall;
    logic [NUM_PERIPH-1:0]          per_valid;
    logic [REG_ADDR_W*NUM_PERIPH-1:0] per_reg;
    logic [DATA_W*NUM_PERIPH-1:0]   per_data;
    logic [NUM_PERIPH-1:0]          per_ready;
    logic [NUM_PERIPH-1:0]          per_error;
    logic                           ctrl_writeEnable;
    logic [REG_ADDR_W-1:0]          ctrl_writeReg;
    logic [DATA_W-1:0]              data_writeReg;
    logic [1:0]                     grant_id;

    modport master (
        output cpu_we, cpu_wreg, cpu_wdata, per_valid, per_reg, per_data,
        input  cpu_stall, per_ready, per_error, ctrl_writeEnable, ctrl_writeReg, data_writeReg, grant_id
    );

    modport slave (
        input  cpu_we, cpu_wreg, cpu_wdata, per_valid, per_reg, per_data,
        output cpu_stall, per_ready, per_error, ctrl_writeEnable, ctrl_writeReg, data_writeReg, grant_id
    );

endinterface

// File: rtl/regfile_write_arbiter_rr.sv
// rtl/regfile_write_arbiter_rr.sv - rr_arbiter: N-way round-robin pick searching upward from the pointer
module rr_arbiter #(
    parameter int N = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    always_comb begin
        logic [IDX_W-1:0] cand;
        cand  = '0;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            cand = IDX_W'((int'(ptr) + k) % N);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - CPU-priority register-file write arbiter; RF_ARB_STARVE_EN adds forced peripheral slots
module regfile_write_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int          NUM_PERIPH      = 2,
    parameter logic [31:0] PERIPH_REG_MASK = DEFAULT_PERIPH_MASK,
    parameter int          STARVE_LIMIT    = 8
) (
    input logic                    clock,
    input logic                    ctrl_reset_n,
    regfile_write_arbiter_if.slave bus
);

    localparam int IDX_W = (NUM_PERIPH > 1) ? $clog2(NUM_PERIPH) : 1;

    if (NUM_PERIPH < 1 || NUM_PERIPH > 4 || STARVE_LIMIT < 2 || STARVE_LIMIT > 255) begin : g_bad_param
        $error("regfile_write_arbiter: parameter out of range");
    end

    arb_state_t            state;
    logic [IDX_W-1:0]      rr_ptr;
    logic [IDX_W-1:0]      rr_idx;
    logic [NUM_PERIPH-1:0] rr_grant;
    logic                  rr_found;
    logic                  cpu_sel;
    logic                  per_sel;
    logic                  per_legal;
    logic [REG_ADDR_W-1:0] win_reg;
    logic [DATA_W-1:0]     win_data;

    rr_arbiter #(
        .N     (NUM_PERIPH),
        .IDX_W (IDX_W)
    ) u_rr (
        .req   (bus.per_valid),
        .ptr   (rr_ptr),
        .grant (rr_grant),
        .idx   (rr_idx),
        .found (rr_found)
    );

    // A peripheral is only offered the slot when the CPU is not taking it and we are out of reset.
    always_comb begin
        cpu_sel   = (state == ARB_NORMAL) && bus.cpu_we;
        per_sel   = ctrl_reset_n && !cpu_sel && rr_found;
        win_reg   = bus.per_reg[int'(rr_idx)*REG_ADDR_W +: REG_ADDR_W];
        win_data  = bus.per_data[int'(rr_idx)*DATA_W +: DATA_W];
        per_legal = reg_legal(PERIPH_REG_MASK, win_reg);
    end

    assign bus.per_ready = per_sel ? rr_grant : '0;

    always_ff @(posedge clock) begin
        if (!ctrl_reset_n) begin
            bus.ctrl_writeEnable <= 1'b0;
            bus.ctrl_writeReg    <= '0;
            bus.data_writeReg    <= '0;
            bus.grant_id         <= GRANT_CPU;
            bus.per_error        <= '0;
            rr_ptr               <= '0;
        end else begin
            bus.ctrl_writeEnable <= 1'b0;
            bus.ctrl_writeReg    <= '0;
            bus.data_writeReg    <= '0;
            bus.grant_id         <= GRANT_CPU;
            bus.per_error        <= '0;
            if (cpu_sel) begin
                bus.ctrl_writeEnable <= 1'b1;
                bus.ctrl_writeReg    <= bus.cpu_wreg;
                bus.data_writeReg    <= bus.cpu_wdata;
            end else if (per_sel) begin
                bus.grant_id <= 2'(rr_idx) + 2'd1;
                if (per_legal) begin
                    bus.ctrl_writeEnable <= 1'b1;
                    bus.ctrl_writeReg    <= win_reg;
                    bus.data_writeReg    <= win_data;
                end else begin
                    bus.per_error <= rr_grant;
                end
                rr_ptr <= (int'(rr_idx) == NUM_PERIPH - 1) ? '0 : rr_idx + IDX_W'(1);
            end
        end
    end

`ifdef RF_ARB_STARVE_EN
    logic [7:0] starve_cnt;

    // FORCE is a one-cycle detour: the stall output is the state register itself.
    always_ff @(posedge clock) begin
        if (!ctrl_reset_n) begin
            state      <= ARB_NORMAL;
            starve_cnt <= '0;
        end else if (state == ARB_FORCE) begin
            state      <= ARB_NORMAL;
            starve_cnt <= '0;
        end else if (per_sel) begin
            starve_cnt <= '0;
        end else if (cpu_sel && (|bus.per_valid)) begin
            if (starve_cnt == 8'(STARVE_LIMIT - 1)) begin
                state      <= ARB_FORCE;
                starve_cnt <= '0;
            end else begin
                starve_cnt <= starve_cnt + 8'd1;
            end
        end
    end

    assign bus.cpu_stall = (state == ARB_FORCE);
`else
    assign state         = ARB_NORMAL;
    assign bus.cpu_stall = 1'b0;
`endif

endmodule
